// File: rtl/clock_divider_prog.sv
// Programmable clock-enable divider: clk_o low for ceil(N/2) cycles, high for the rest; tick_o marks each wrap.
// Outputs are registered; new divisors are held pending and applied only at a wrap, so no short or long pulses occur.
module clock_divider_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 6
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic             load_i,
   output logic             clk_o,
   output logic             tick_o,
   output logic             pending_o,
   output logic             reject_o
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] n_act;
   logic [WIDTH-1:0] n_pend;
   logic [WIDTH:0]   half;
   logic [WIDTH:0]   half_m1;
   logic             wrap;
   logic             rise;
   logic             div_ok;

   // One extra bit keeps (n_act+1) from overflowing at the maximum divisor.
   assign half    = ({1'b0, n_act} + (WIDTH+1)'(1)) >> 1;
   assign half_m1 = half - (WIDTH+1)'(1);
   assign wrap    = (cnt == (n_act - WIDTH'(1)));
   assign rise    = ({1'b0, cnt} == half_m1);
   assign div_ok  = (div_i >= WIDTH'(2));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt       <= '0;
         n_act     <= WIDTH'(DEFAULT_DIV);
         n_pend    <= '0;
         pending_o <= 1'b0;
         clk_o     <= 1'b0;
         tick_o    <= 1'b0;
         reject_o  <= 1'b0;
      end else begin
         reject_o <= 1'b0;
         tick_o   <= 1'b0;
         if (enable_i) begin
            if (wrap) begin
               cnt    <= '0;
               clk_o  <= 1'b0;
               tick_o <= 1'b1;
               if (pending_o) begin
                  n_act     <= n_pend;
                  pending_o <= 1'b0;
               end
            end else begin
               cnt <= cnt + WIDTH'(1);
               if (rise) begin
                  clk_o <= 1'b1;
               end
            end
         end
         // A load on the wrap cycle overrides the pending clear above: the old
         // n_pend is consumed at this wrap and the new value waits for the next one.
         if (load_i) begin
            if (div_ok) begin
               n_pend    <= div_i;
               pending_o <= 1'b1;
            end else begin
               reject_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: tracks the expected counter position and checks clk_o/tick_o/pending_o each cycle.
module tb_clock_divider_prog;

   localparam int WIDTH = 8;

   logic             clk_i = 1'b0;
   logic             reset_i = 1'b1;
   logic             enable_i = 1'b0;
   logic [WIDTH-1:0] div_i = '0;
   logic             load_i = 1'b0;
   logic             clk_o;
   logic             tick_o;
   logic             pending_o;
   logic             reject_o;

   int    checks = 0;
   int    errors = 0;
   int    ecnt = 0;
   string phase = "init";

   clock_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(6)) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .enable_i  (enable_i),
      .div_i     (div_i),
      .load_i    (load_i),
      .clk_o     (clk_o),
      .tick_o    (tick_o),
      .pending_o (pending_o),
      .reject_o  (reject_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s/%s got=%0d exp=%0d (t=%0t)", phase, tag, got, exp, $time);
      end
   endtask

   // One posedge with the current inputs; n is the divisor governing this cycle.
   task automatic cyc(input int n, input int exp_pend);
      int h;
      @(posedge clk_i);
      #1;
      if (enable_i) ecnt = (ecnt == n - 1) ? 0 : ecnt + 1;
      h = (n + 1) / 2;
      chk("tick", int'(tick_o), (enable_i && ecnt == 0) ? 1 : 0);
      chk("clk",  int'(clk_o),  (ecnt >= h) ? 1 : 0);
      chk("pend", int'(pending_o), exp_pend);
   endtask

   task automatic run(input int cycles, input int n, input int exp_pend);
      for (int i = 0; i < cycles; i++) cyc(n, exp_pend);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      ecnt = 0;
      chk("rst_clk",  int'(clk_o), 0);
      chk("rst_tick", int'(tick_o), 0);
      chk("rst_pend", int'(pending_o), 0);
      chk("rst_rej",  int'(reject_o), 0);
   endtask

   initial begin
      phase = "reset";
      @(posedge clk_i);
      #1;
      do_reset();

      // Default divide-by-6: 4 full periods, ticks at enabled cycles 6/12/18/24.
      phase = "div6";
      enable_i = 1'b1;
      run(24, 6, 0);

      // Divisors below 2 are rejected and leave the period untouched.
      phase = "reject";
      load_i = 1'b1;
      div_i  = 8'd1;
      cyc(6, 0);
      chk("rej1", int'(reject_o), 1);
      div_i = 8'd0;
      cyc(6, 0);
      chk("rej0", int'(reject_o), 1);
      load_i = 1'b0;
      cyc(6, 0);
      chk("rej_clear", int'(reject_o), 0);
      run(3, 6, 0);

      // Load 5 at cycle 2: current period still 6 long, then 5-cycle periods.
      phase = "load5";
      run(2, 6, 0);
      load_i = 1'b1;
      div_i  = 8'd5;
      cyc(6, 1);
      chk("rej_ok", int'(reject_o), 0);
      load_i = 1'b0;
      run(2, 6, 1);
      cyc(6, 0);
      run(10, 5, 0);

      // Pending 3, then load 4 on the wrap: one 3-cycle period, then 4-cycle periods.
      phase = "wrapload";
      load_i = 1'b1;
      div_i  = 8'd3;
      cyc(5, 1);
      load_i = 1'b0;
      run(3, 5, 1);
      load_i = 1'b1;
      div_i  = 8'd4;
      cyc(5, 1);
      load_i = 1'b0;
      run(2, 3, 1);
      cyc(3, 0);
      run(8, 4, 0);

      // Back to 6, then freeze for 7 cycles at cnt=4 in the high phase.
      phase = "freeze";
      load_i = 1'b1;
      div_i  = 8'd6;
      cyc(4, 1);
      load_i = 1'b0;
      run(2, 4, 1);
      cyc(4, 0);
      run(4, 6, 0);
      enable_i = 1'b0;
      run(7, 6, 0);
      enable_i = 1'b1;
      cyc(6, 0);
      chk("resume_no_tick", int'(tick_o), 0);
      cyc(6, 0);
      chk("resume_tick", int'(tick_o), 1);

      // Maximum divisor 255: 128 low / 127 high.
      phase = "div255";
      load_i = 1'b1;
      div_i  = 8'd255;
      cyc(6, 1);
      load_i = 1'b0;
      run(4, 6, 1);
      cyc(6, 0);
      run(255, 255, 0);

      // Reset mid-period with 9 pending discards it; divisor returns to 6.
      phase = "midreset";
      run(10, 255, 0);
      load_i = 1'b1;
      div_i  = 8'd9;
      cyc(255, 1);
      load_i = 1'b0;
      run(3, 255, 1);
      do_reset();
      run(12, 6, 0);

      // Divide-by-2: clk_o toggles every cycle, tick every second cycle.
      phase = "div2";
      load_i = 1'b1;
      div_i  = 8'd2;
      cyc(6, 1);
      load_i = 1'b0;
      run(4, 6, 1);
      cyc(6, 0);
      run(6, 2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
